mul_ctrl: RTL
=============

MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 Parameters: LAT, default 9, multiplier request-to-result latency in cycles; WDT, default 15, WAIT-state watchdog limit in cycles.
REQ-002 clk  in  1  single clock; all state is updated on the rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 ex_valid_i  in  1  execute stage presents an M-extension operation.
REQ-005 ex_ready_o  out  1  controller can accept an operation.
REQ-006 ex_op_i  in  2  operation code: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 ex_word_i  in  1  MULW; only legal when ex_op_i=00.
REQ-008 rs1_i, rs2_i  in  64 each  source operands.
REQ-009 rd_i  in  5  destination register.
REQ-010 flush_i  in  1  pipeline kill.
REQ-011 mul_req_valid_o, mul_block_o  out  1 each  multiplier request and multiplier block.
REQ-012 mul_op_1_o, mul_op_2_o  out  64 each  multiplier operands.
REQ-013 mul_sign_op_1_o, mul_sign_op_2_o  out  1 each  operand signedness.
REQ-014 mul_result_l_i, mul_result_h_i  in  64 each  multiplier product halves.
REQ-015 mul_valid_i  in  1  multiplier result valid.
REQ-016 wb_valid_o, wb_ready_i  out/in  1 each  writeback handshake.
REQ-017 wb_data_o  out  64  writeback data.
REQ-018 wb_rd_o  out  5  writeback destination register.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-020 ex_ready_o SHALL equal (state==IDLE).
REQ-021 Accept on ex_valid_i & ex_ready_o & ~flush_i: register the operands, op, word and rd.
REQ-022 If either operand is zero on accept, then:
- the transition SHALL be IDLE->DONE;
- the result SHALL be 0;
- no multiplier request SHALL be issued.
REQ-023 On any other accept, the transition SHALL be IDLE->ISSUE.
REQ-024 Operand formatting:
- MULW SHALL present sext(rs[31:0]) with both signs = 1;
- MUL SHALL use signs 0/0;
- MULH SHALL use signs 1/1;
- MULHSU SHALL use signs 1/0;
- MULHU SHALL use signs 0/0.
REQ-025 mul_op_*_o and mul_sign_*_o SHALL be held stable from ISSUE until the controller leaves WAIT.
REQ-026 In ISSUE, mul_req_valid_o SHALL be 1 for exactly one cycle, then the transition SHALL be ISSUE->WAIT; mul_req_valid_o SHALL be 0 in all other states.
REQ-027 In WAIT, a cycle counter SHALL count from 1 upward.
REQ-028 In WAIT, when mul_valid_i=1 and counter >= LAT-1, the result SHALL be captured and the transition SHALL be WAIT->DONE.
REQ-029 Result selection:
- MUL SHALL select result_l;
- MULW SHALL select sext(result_l[31:0]);
- MULH, MULHSU and MULHU SHALL select result_h.
REQ-030 With LAT=9, wb_valid_o SHALL first assert 10 cycles after the accept edge.
REQ-031 If the WAIT counter reaches WDT without a capture:
- mul_block_o SHALL assert for 1 cycle;
- wb_data_o SHALL be 0;
- the transition SHALL be WAIT->DONE.
REQ-032 In DONE, wb_valid_o SHALL be 1 and wb_data_o and wb_rd_o SHALL be held stable until wb_ready_i=1; then the transition SHALL be DONE->IDLE.
REQ-033 No new accept SHALL occur in the same cycle as the DONE->IDLE transition.
REQ-034 flush_i in ISSUE or WAIT SHALL assert mul_block_o for that cycle and force IDLE next cycle, with no wb_valid_o.
REQ-035 flush_i in DONE SHALL drop the result and force IDLE.
REQ-036 flush_i in IDLE SHALL block the accept.
REQ-037 mul_block_o SHALL be 0 except in the cases of REQ-031 and REQ-034.

Reset
REQ-038 When rst=0, the controller SHALL take these values immediately:
- state SHALL be IDLE and all counters 0;
- ex_ready_o SHALL be 1;
- mul_req_valid_o, mul_block_o, mul_sign_*_o and wb_valid_o SHALL be 0;
- mul_op_*_o, wb_data_o and wb_rd_o SHALL be 0.
REQ-039 Reset asserted mid-operation SHALL discard the in-flight operation without producing any wb_valid_o.

Verification
REQ-040 MUL rs1=3, rs2=5, rd=7, wb_ready_i=1 -> one mul_req_valid_o pulse; wb_valid_o at accept+10 cycles; wb_data_o=15; wb_rd_o=7.
REQ-041 MULH -1 x -1 -> signs 1/1, wb_data_o=0; MULHU 0xFFFF_FFFF_FFFF_FFFF x 2 -> wb_data_o=1.
REQ-042 MULHSU rs1=-1, rs2=2 -> signs 1/0, wb_data_o=0xFFFF_FFFF_FFFF_FFFF; MULW 0x7FFF_FFFF x 2 -> wb_data_o=0xFFFF_FFFF_FFFF_FFFE.
REQ-043 Zero operand: rs2=0 -> no mul_req_valid_o; wb_valid_o 1 cycle after accept; wb_data_o=0.
REQ-044 wb_ready_i held 0 for 5 cycles in DONE -> wb_valid_o, wb_data_o and wb_rd_o stay stable and ex_ready_o=0 throughout; released -> IDLE.
REQ-045 flush_i at WAIT cycle 4 -> mul_block_o=1 for 1 cycle, IDLE next cycle, no wb_valid_o; rst=0 at WAIT cycle 3 -> all outputs take their reset values immediately.

Source files
------------

// File: rtl/mul_ctrl_if.sv
// Execute/multiplier/writeback signal bundle for the M-extension multiply controller.
// The controller connects through the slave modport; the surrounding pipeline drives the master side.
interface mul_ctrl_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_op;
  logic        ex_word;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [4:0]  rd;
  logic        flush;

  logic        mul_req_valid;
  logic        mul_block;
  logic [63:0] mul_op_1;
  logic [63:0] mul_op_2;
  logic        mul_sign_op_1;
  logic        mul_sign_op_2;
  logic [63:0] mul_result_l;
  logic [63:0] mul_result_h;
  logic        mul_valid;

  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;

  modport slave (
    input  ex_valid, ex_op, ex_word, rs1, rs2, rd, flush,
    input  mul_result_l, mul_result_h, mul_valid, wb_ready,
    output ex_ready, mul_req_valid, mul_block, mul_op_1, mul_op_2,
    output mul_sign_op_1, mul_sign_op_2, wb_valid, wb_data, wb_rd
  );

  modport master (
    output ex_valid, ex_op, ex_word, rs1, rs2, rd, flush,
    output mul_result_l, mul_result_h, mul_valid, wb_ready,
    input  ex_ready, mul_req_valid, mul_block, mul_op_1, mul_op_2,
    input  mul_sign_op_1, mul_sign_op_2, wb_valid, wb_data, wb_rd
  );
endinterface

// File: rtl/mul_ctrl.sv
// Sequences one MUL/MULH/MULHSU/MULHU/MULW operation through an external multiplier.
// state | meaning
// IDLE  | ready for a new operation
// ISSUE | one-cycle multiplier request
// WAIT  | counting cycles until the product (or watchdog) arrives
// DONE  | result held on the writeback port until taken
module mul_ctrl #(
  parameter int LAT = 9,
  parameter int WDT = 15
) (
  input logic clk,
  input logic rst_n,
  mul_ctrl_if.slave bus
);
  localparam int CW = $clog2(WDT + 1) + 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(LAT - 1);
  localparam logic [CW-1:0] WDT_C  = CW'(WDT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic          word_q;
  logic [63:0]   op_1_q, op_2_q, wb_data_q;
  logic          sign_1_q, sign_2_q;
  logic [4:0]    wb_rd_q;

  logic          accept, zero_op, capture, timeout, word_fmt;
  logic          req, block;
  logic [63:0]   op_1_fmt, op_2_fmt, result_sel;
  logic          sign_1_fmt, sign_2_fmt;

  assign accept   = bus.ex_valid & (state == IDLE) & ~bus.flush;
  assign zero_op  = (bus.rs1 == 64'd0) | (bus.rs2 == 64'd0);
  assign word_fmt = bus.ex_word & (bus.ex_op == 2'b00);
  assign capture  = (state == WAIT) & ~bus.flush & bus.mul_valid & (cnt >= LAT_M1);
  assign timeout  = (state == WAIT) & ~bus.flush & ~capture & (cnt >= WDT_C);

  always_comb begin
    op_1_fmt   = bus.rs1;
    op_2_fmt   = bus.rs2;
    sign_1_fmt = 1'b0;
    sign_2_fmt = 1'b0;
    if (word_fmt) begin
      op_1_fmt   = {{32{bus.rs1[31]}}, bus.rs1[31:0]};
      op_2_fmt   = {{32{bus.rs2[31]}}, bus.rs2[31:0]};
      sign_1_fmt = 1'b1;
      sign_2_fmt = 1'b1;
    end else begin
      case (bus.ex_op)
        2'b01: begin sign_1_fmt = 1'b1; sign_2_fmt = 1'b1; end
        2'b10: sign_1_fmt = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    if (word_q)             result_sel = {{32{bus.mul_result_l[31]}}, bus.mul_result_l[31:0]};
    else if (op_q == 2'b00) result_sel = bus.mul_result_l;
    else                    result_sel = bus.mul_result_h;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    block    = 1'b0;
    case (state)
      IDLE:  if (accept) state_nx = zero_op ? DONE : ISSUE;
      ISSUE: begin
        if (bus.flush) begin
          block    = 1'b1;
          state_nx = IDLE;
        end else begin
          req      = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          block    = 1'b1;
          state_nx = IDLE;
        end else if (capture) begin
          state_nx = DONE;
        end else if (timeout) begin
          block    = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:  if (bus.flush || bus.wb_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // WAIT cycle counter: 1 in the first WAIT cycle, cleared everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (state_nx == WAIT)  cnt <= (state == WAIT) ? cnt + 1'b1 : CW'(1);
    else                        cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 2'b00;
      word_q    <= 1'b0;
      op_1_q    <= '0;
      op_2_q    <= '0;
      sign_1_q  <= 1'b0;
      sign_2_q  <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
    end else begin
      if (accept) begin
        op_q     <= bus.ex_op;
        word_q   <= word_fmt;
        op_1_q   <= op_1_fmt;
        op_2_q   <= op_2_fmt;
        sign_1_q <= sign_1_fmt;
        sign_2_q <= sign_2_fmt;
        wb_rd_q  <= bus.rd;
        if (zero_op) wb_data_q <= '0;
      end
      if (capture)      wb_data_q <= result_sel;
      else if (timeout) wb_data_q <= '0;
    end
  end

  assign bus.ex_ready      = (state == IDLE);
  assign bus.mul_req_valid = req;
  assign bus.mul_block     = block;
  assign bus.mul_op_1      = op_1_q;
  assign bus.mul_op_2      = op_2_q;
  assign bus.mul_sign_op_1 = sign_1_q;
  assign bus.mul_sign_op_2 = sign_2_q;
  assign bus.wb_valid      = (state == DONE);
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_rd         = wb_rd_q;
endmodule
